// File: rtl/host_bus_responder.sv
// rtl/host_bus_responder.sv - host end of the 6502 socket bus: phi0 generation, memory port, read/write service
// Optional 1MHz clock stretch for slow I/O is enabled by defining HOST_1MHZ_STRETCH_EN.
module host_bus_responder #(
  parameter int DIV = 4
) (
  input  logic        hsclk,
  input  logic        resetb,
  output logic        bbc_phi0,
  input  logic [15:0] bbc_a,
  input  logic        bbc_rnw,
  input  logic        bbc_sync,
  input  logic [7:0]  bbc_d_in,
  output logic [7:0]  bbc_d_out,
  output logic        bbc_d_oe,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  output logic        slow_cyc
);

  localparam logic [3:0] HC_LAST = 4'(DIV - 1);
  localparam logic [5:0] M_LAST  = 6'(4 * DIV - 1);

  typedef enum logic [1:0] {
    ST_LOW          = 2'd0,
    ST_HIGH         = 2'd1,
    ST_HIGH_STRETCH = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_hc;
  logic [3:0]  w_hc_nxt;
  logic [5:0]  r_m;
  logic        w_hc_last;
  logic        w_m_last;
  logic        w_rise;
  logic        w_fall;
  logic        w_slow;

  logic [15:0] r_addr;
  logic        r_rnw;
  logic        r_sync;
  logic        r_mem_re;
  logic        r_mem_we;
  logic [7:0]  r_wdata;
  logic        r_rd_live;
  logic [7:0]  r_d_out;
  logic        r_oe;
  logic        w_unused_sync;

  assign w_hc_last = (r_hc == HC_LAST);
  assign w_m_last  = (r_m == M_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_hc_nxt    = r_hc + 4'd1;
    case (r_state)
      ST_LOW: begin
        if (w_hc_last) begin
          w_state_nxt = ST_HIGH;
          w_hc_nxt    = '0;
        end
      end
      ST_HIGH: begin
        if (w_hc_last) begin
          w_hc_nxt = '0;
          // a slow cycle whose nominal end already lands on the 1MHz edge needs no stretch
          if (w_slow && !w_m_last) w_state_nxt = ST_HIGH_STRETCH;
          else                     w_state_nxt = ST_LOW;
        end
      end
      ST_HIGH_STRETCH: begin
        w_hc_nxt = '0;
        if (w_m_last) w_state_nxt = ST_LOW;
      end
      default: begin
        w_state_nxt = ST_LOW;
        w_hc_nxt    = '0;
      end
    endcase
  end

  assign w_rise = (r_state == ST_LOW) && w_hc_last;
  assign w_fall = (r_state != ST_LOW) && (w_state_nxt == ST_LOW);

  always_ff @(posedge hsclk) begin
    if (!resetb) begin
      r_state   <= ST_LOW;
      r_hc      <= '0;
      r_m       <= '0;
      r_addr    <= '0;
      r_rnw     <= 1'b1;
      r_sync    <= 1'b0;
      r_mem_re  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_wdata   <= '0;
      r_rd_live <= 1'b0;
      r_d_out   <= '0;
      r_oe      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hc      <= w_hc_nxt;
      r_m       <= w_m_last ? 6'd0 : r_m + 6'd1;
      r_mem_re  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_rd_live <= r_mem_re;
      if (r_rd_live) r_d_out <= mem_rdata;
      if (r_mem_re)  r_oe    <= 1'b1;
      if (w_rise) begin
        r_addr   <= bbc_a;
        r_rnw    <= bbc_rnw;
        r_sync   <= bbc_sync;
        r_mem_re <= bbc_rnw;
      end
      if (w_fall) begin
        r_oe <= 1'b0;
        if (!r_rnw) begin
          r_mem_we <= 1'b1;
          r_wdata  <= bbc_d_in;
        end
      end
    end
  end

`ifdef HOST_1MHZ_STRETCH_EN
  logic r_slow;
  logic w_slow_dec;

  assign w_slow_dec = (bbc_a[15:9] == 7'h7E)  ||
                      (bbc_a[15:5] == 11'h7F0) ||
                      (bbc_a[15:6] == 10'h3F9) ||
                      (bbc_a[15:5] == 11'h7F6);

  always_ff @(posedge hsclk) begin
    if (!resetb)     r_slow <= 1'b0;
    else if (w_rise) r_slow <= w_slow_dec;
    else if (w_fall) r_slow <= 1'b0;
  end

  assign w_slow = r_slow;
`else
  assign w_slow = 1'b0;
`endif

  assign w_unused_sync = r_sync;

  // read data passes straight through while it is fresh, then the captured copy is held
  assign bbc_d_out = r_rd_live ? mem_rdata : r_d_out;
  assign bbc_d_oe  = r_oe;
  assign bbc_phi0  = (r_state != ST_LOW);
  assign mem_addr  = r_addr;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_wdata;
  assign slow_cyc  = w_slow;

endmodule

// File: tb/tb_host_bus_responder.sv
// tb/tb_host_bus_responder.sv - directed bench for host_bus_responder with DIV=4
module tb_host_bus_responder;

`ifdef HOST_1MHZ_STRETCH_EN
  localparam int SLOW_LEN = 12;
  localparam int SLOW_ON  = 1;
  localparam int RST_AT   = 6;
`else
  localparam int SLOW_LEN = 4;
  localparam int SLOW_ON  = 0;
  localparam int RST_AT   = 2;
`endif

  logic        hsclk      = 1'b0;
  logic        resetb     = 1'b0;
  logic [15:0] bbc_a      = 16'h0000;
  logic        bbc_rnw    = 1'b1;
  logic        bbc_sync   = 1'b0;
  logic [7:0]  bbc_d_in   = 8'h00;
  logic [7:0]  mem_rdata  = 8'h00;
  logic [7:0]  mem_rd_val = 8'h00;
  logic        bbc_phi0;
  logic [7:0]  bbc_d_out;
  logic        bbc_d_oe;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        slow_cyc;

  int checks = 0;
  int errors = 0;

  host_bus_responder #(.DIV(4)) dut (
    .hsclk     (hsclk),
    .resetb    (resetb),
    .bbc_phi0  (bbc_phi0),
    .bbc_a     (bbc_a),
    .bbc_rnw   (bbc_rnw),
    .bbc_sync  (bbc_sync),
    .bbc_d_in  (bbc_d_in),
    .bbc_d_out (bbc_d_out),
    .bbc_d_oe  (bbc_d_oe),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .slow_cyc  (slow_cyc)
  );

  always #5 hsclk = ~hsclk;

  // synchronous memory: data appears the cycle after the read strobe
  always @(posedge hsclk) if (mem_re) mem_rdata <= mem_rd_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge hsclk);
  endtask

  task automatic phase(input logic lvl, output int n, output int re_n, output int we_n,
                       output int oe_n, output int slow_n);
    n = 0; re_n = 0; we_n = 0; oe_n = 0; slow_n = 0;
    while (bbc_phi0 === lvl && n < 200) begin
      n++;
      re_n   += int'(mem_re);
      we_n   += int'(mem_we);
      oe_n   += int'(bbc_d_oe);
      slow_n += int'(slow_cyc);
      step;
    end
  endtask

  task automatic wait_rise(output int n, output int we_n);
    n = 0; we_n = 0;
    while (bbc_phi0 !== 1'b1 && n < 100) begin
      step;
      n++;
      we_n += int'(mem_we);
    end
  endtask

  initial begin
    int n, re_n, we_n, oe_n, slow_n;

    bbc_a = 16'h1234; bbc_rnw = 1'b1; mem_rd_val = 8'hA5;
    repeat (3) step;
    check("rst_phi0", bbc_phi0, 1'b0);
    check("rst_oe", bbc_d_oe, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_re", mem_re, 1'b0);
    check("rst_slow", slow_cyc, 1'b0);
    check("rst_dout", bbc_d_out, 8'h00);
    check("rst_addr", mem_addr, 16'h0000);

    resetb = 1'b1;
    wait_rise(n, we_n);
    check("rst_to_rise", n, 4);

    check("rd_re", mem_re, 1'b1);
    check("rd_addr", mem_addr, 16'h1234);
    check("rd_oe_c0", bbc_d_oe, 1'b0);
    step;
    check("rd_re_one", mem_re, 1'b0);
    check("rd_oe_c1", bbc_d_oe, 1'b1);
    check("rd_dout_c1", bbc_d_out, 8'hA5);
    step;
    step;
    check("rd_oe_c3", bbc_d_oe, 1'b1);
    check("rd_phi_c3", bbc_phi0, 1'b1);
    bbc_a = 16'h2000; bbc_rnw = 1'b0; bbc_d_in = 8'h5A;
    step;
    check("rd_fall_phi", bbc_phi0, 1'b0);
    check("rd_fall_oe", bbc_d_oe, 1'b0);
    check("rd_fall_dout", bbc_d_out, 8'hA5);
    check("rd_no_we", mem_we, 1'b0);
    phase(1'b0, n, re_n, we_n, oe_n, slow_n);
    check("low_len", n, 4);

    phase(1'b1, n, re_n, we_n, oe_n, slow_n);
    check("wr_high_len", n, 4);
    check("wr_no_re", re_n, 0);
    check("wr_we_fall", mem_we, 1'b1);
    check("wr_wdata", mem_wdata, 8'h5A);
    check("wr_addr", mem_addr, 16'h2000);
    bbc_a = 16'hFE40; bbc_rnw = 1'b1; mem_rd_val = 8'h3C;
    phase(1'b0, n, re_n, we_n, oe_n, slow_n);
    check("wr_low_len", n, 4);
    check("wr_we_once", we_n, 1);

    phase(1'b1, n, re_n, we_n, oe_n, slow_n);
    check("fe40_high_len", n, SLOW_LEN);
    check("fe40_re_once", re_n, 1);
    check("fe40_oe_len", oe_n, SLOW_LEN - 1);
    check("fe40_slow", slow_n, SLOW_ON * SLOW_LEN);
    check("fe40_dout", bbc_d_out, 8'h3C);
    check("fe40_fall_oe", bbc_d_oe, 1'b0);
    bbc_a = 16'hFE20; mem_rd_val = 8'h77;
    phase(1'b0, n, re_n, we_n, oe_n, slow_n);
    check("fe40_low_len", n, 4);

    phase(1'b1, n, re_n, we_n, oe_n, slow_n);
    check("fe20_high_len", n, 4);
    check("fe20_slow", slow_n, 0);
    check("fe20_dout", bbc_d_out, 8'h77);
    bbc_a = 16'hFC00;
    phase(1'b0, n, re_n, we_n, oe_n, slow_n);

    phase(1'b1, n, re_n, we_n, oe_n, slow_n);
    check("fc00_edge_len", n, 4);
    check("fc00_edge_slow", slow_n, SLOW_ON * 4);
    bbc_rnw = 1'b0; bbc_d_in = 8'hC3;
    phase(1'b0, n, re_n, we_n, oe_n, slow_n);

    repeat (RST_AT) step;
    check("wrs_phi_pre", bbc_phi0, 1'b1);
    check("wrs_slow_pre", slow_cyc, 1'(SLOW_ON));
    resetb = 1'b0;
    step;
    check("wrs_phi", bbc_phi0, 1'b0);
    check("wrs_oe", bbc_d_oe, 1'b0);
    check("wrs_we", mem_we, 1'b0);
    check("wrs_slow", slow_cyc, 1'b0);
    check("wrs_addr", mem_addr, 16'h0000);
    step;
    check("wrs_we2", mem_we, 1'b0);
    bbc_a = 16'hFE40; bbc_rnw = 1'b1; mem_rd_val = 8'h81;
    resetb = 1'b1;
    wait_rise(n, we_n);
    check("wrs_to_rise", n, 4);
    check("wrs_no_we", we_n, 0);
    phase(1'b1, n, re_n, we_n, oe_n, slow_n);
    check("wrs_fe40_len", n, SLOW_LEN);
    check("wrs_fe40_dout", bbc_d_out, 8'h81);
    check("wrs_fe40_no_we", we_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
